// File: rtl/read_return_buf.sv
// Read return buffer: one slot per outstanding read burst, beats reassembled by tag,
// completed bursts drained to the host lowest-index first.
//
// Drain FSM states:
//   state   | meaning
//   D_IDLE  | no burst draining; picks lowest DONE slot at the next edge
//   D_SEND  | streaming beats of slot cur_q to the host
module read_return_buf #(
  parameter int NUM_ENTRIES = 8,
  parameter int BURST_LEN   = 8,
  parameter int DATA_W      = 64,
  parameter int ID_W        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_valid_i,
  input  logic [ID_W-1:0]                 alloc_id_i,
  output logic                            alloc_ready_o,
  output logic [$clog2(NUM_ENTRIES)-1:0]  alloc_idx_o,
  input  logic                            ret_valid_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0]  ret_tag_i,
  input  logic [DATA_W-1:0]               ret_data_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [ID_W-1:0]                 resp_id_o,
  output logic [DATA_W-1:0]               resp_data_o,
  output logic                            resp_last_o,
  output logic [$clog2(NUM_ENTRIES):0]    free_count_o,
  output logic                            err_stray_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {SL_FREE, SL_WAIT, SL_DONE, SL_SEND} slot_e;
  typedef enum logic {D_IDLE, D_SEND} drain_e;

  slot_e            slot_q [NUM_ENTRIES];
  slot_e            slot_d [NUM_ENTRIES];
  logic [ID_W-1:0]  id_q   [NUM_ENTRIES];
  logic [ID_W-1:0]  id_d   [NUM_ENTRIES];
  logic [CNT_W-1:0] cnt_q  [NUM_ENTRIES];
  logic [CNT_W-1:0] cnt_d  [NUM_ENTRIES];
  logic [DATA_W-1:0] mem_q [NUM_ENTRIES][BURST_LEN];

  drain_e           drain_q, drain_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             err_stray_q, err_stray_d;

  logic             any_done;
  logic [IDX_W-1:0] done_idx;
  logic             alloc_fire, ret_hit, sel, rel;

  // Priority searches: descending loop so the lowest matching index wins.
  always_comb begin
    alloc_ready_o = 1'b0;
    alloc_idx_o   = '0;
    free_count_o  = '0;
    any_done      = 1'b0;
    done_idx      = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (slot_q[i] == SL_FREE) begin
        alloc_ready_o = 1'b1;
        alloc_idx_o   = IDX_W'(i);
        free_count_o  = free_count_o + (IDX_W + 1)'(1);
      end
      if (slot_q[i] == SL_DONE) begin
        any_done = 1'b1;
        done_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_fire  = alloc_valid_i && alloc_ready_o;
  assign ret_hit     = ret_valid_i && (slot_q[ret_tag_i] == SL_WAIT);
  assign err_stray_d = ret_valid_i && !ret_hit;
  assign err_stray_o = err_stray_q;

  // Each event can only touch a slot in its own state, so they never collide.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      slot_d[i] = slot_q[i];
      id_d[i]   = id_q[i];
      cnt_d[i]  = cnt_q[i];
      if (alloc_fire && alloc_idx_o == IDX_W'(i)) begin
        slot_d[i] = SL_WAIT;
        id_d[i]   = alloc_id_i;
        cnt_d[i]  = '0;
      end
      if (ret_hit && ret_tag_i == IDX_W'(i)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (cnt_q[i] == LAST) slot_d[i] = SL_DONE;
      end
      if (sel && done_idx == IDX_W'(i)) slot_d[i] = SL_SEND;
      if (rel && cur_q == IDX_W'(i))    slot_d[i] = SL_FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slot_q[i] <= SL_FREE;
        id_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
      err_stray_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slot_q[i] <= slot_d[i];
        id_q[i]   <= id_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      err_stray_q <= err_stray_d;
    end
  end

  // Beat storage needs no reset: it is only visible through a slot in SEND.
  always_ff @(posedge clk) begin
    if (ret_hit) mem_q[ret_tag_i][cnt_q[ret_tag_i]] <= ret_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_q <= D_IDLE;
      cur_q   <= '0;
      beat_q  <= '0;
    end else begin
      drain_q <= drain_d;
      cur_q   <= cur_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    drain_d = drain_q;
    cur_d   = cur_q;
    beat_d  = beat_q;
    case (drain_q)
      D_IDLE: begin
        if (any_done) begin
          drain_d = D_SEND;
          cur_d   = done_idx;
          beat_d  = '0;
        end
      end
      D_SEND: begin
        if (resp_ready_i) begin
          if (beat_q == LAST) begin
            drain_d = D_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: drain_d = D_IDLE;
    endcase
  end

  always_comb begin
    resp_valid_o = (drain_q == D_SEND);
    resp_last_o  = resp_valid_o && (beat_q == LAST);
    resp_id_o    = resp_valid_o ? id_q[cur_q] : '0;
    resp_data_o  = resp_valid_o ? mem_q[cur_q][beat_q] : '0;
    sel          = (drain_q == D_IDLE) && any_done;
    rel          = resp_valid_o && resp_ready_i && resp_last_o;
  end

endmodule

// File: tb/tb_read_return_buf.sv
// Bench for read_return_buf: transaction-level slot model feeds an expected-beat queue;
// a negedge monitor compares every presented response beat against it.
module tb_read_return_buf;
  localparam int NE = 8, BL = 8, DW = 64, IW = 4, XW = 3;
  localparam int M_FREE = 0, M_WAIT = 1, M_DONE = 2, M_SEND = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          alloc_valid = 0, ret_valid = 0, resp_ready = 0;
  logic [IW-1:0] alloc_id = '0;
  logic [XW-1:0] ret_tag = '0;
  logic [DW-1:0] ret_data = '0;
  logic          alloc_ready, resp_valid, resp_last, err_stray;
  logic [XW-1:0] alloc_idx;
  logic [IW-1:0] resp_id;
  logic [DW-1:0] resp_data;
  logic [XW:0]   free_count;

  read_return_buf #(.NUM_ENTRIES(NE), .BURST_LEN(BL), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_id_i(alloc_id),
    .alloc_ready_o(alloc_ready), .alloc_idx_o(alloc_idx),
    .ret_valid_i(ret_valid), .ret_tag_i(ret_tag), .ret_data_i(ret_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_data_o(resp_data), .resp_last_o(resp_last),
    .free_count_o(free_count), .err_stray_o(err_stray)
  );

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot status, stored id, collected beats, and the drain in progress.
  int            m_st [NE];
  logic [IW-1:0] m_id [NE];
  logic [DW-1:0] m_beats [NE][$];
  bit            m_busy;
  int            m_cur, m_sent;

  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic last;} beat_t;
  beat_t exp_q[$];

  function automatic int m_low(input int st);
    for (int i = 0; i < NE; i++) if (m_st[i] == st) return i;
    return -1;
  endfunction

  function automatic int m_count(input int st);
    int n = 0;
    for (int i = 0; i < NE; i++) if (m_st[i] == st) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_st[i] = M_FREE;
      m_beats[i].delete();
    end
    m_busy = 0; m_cur = 0; m_sent = 0;
    exp_q.delete();
  endtask

  // One clock with the currently driven inputs; model advanced from pre-edge state.
  task automatic step();
    int lf, ld;
    bit do_alloc, do_ret, stray, do_sel, hs;
    logic [XW-1:0] tag;
    lf = m_low(M_FREE);
    ld = m_low(M_DONE);
    chk("free_count", DW'(free_count), DW'(m_count(M_FREE)));
    chk("alloc_ready", DW'(alloc_ready), DW'(lf >= 0));
    chk("alloc_idx", DW'(alloc_idx), DW'(lf >= 0 ? lf : 0));
    tag      = ret_tag;
    do_alloc = alloc_valid && lf >= 0;
    do_ret   = ret_valid && m_st[tag] == M_WAIT;
    stray    = ret_valid && !do_ret;
    do_sel   = !m_busy && ld >= 0;
    hs       = m_busy && resp_ready;
    @(posedge clk);
    #1;
    if (do_alloc) begin
      m_st[lf] = M_WAIT;
      m_id[lf] = alloc_id;
      m_beats[lf].delete();
    end
    if (do_ret) begin
      m_beats[tag].push_back(ret_data);
      if (m_beats[tag].size() == BL) m_st[tag] = M_DONE;
    end
    if (hs) begin
      m_sent++;
      if (m_sent == BL) begin
        m_st[m_cur] = M_FREE;
        m_busy = 0;
      end
    end
    if (do_sel) begin
      m_st[ld] = M_SEND;
      m_busy = 1; m_cur = ld; m_sent = 0;
      for (int i = 0; i < BL; i++) exp_q.push_back('{m_id[ld], m_beats[ld][i], i == BL - 1});
    end
    chk("resp_valid", DW'(resp_valid), DW'(m_busy));
    chk("err_stray", DW'(err_stray), DW'(stray));
  endtask

  // Monitor: every presented beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL resp_unexpected: got beat %0h expected none", resp_data);
        end else begin
          chk("resp_id", DW'(resp_id), DW'(exp_q[0].id));
          chk("resp_data", resp_data, exp_q[0].data);
          chk("resp_last", DW'(resp_last), DW'(exp_q[0].last));
          if (resp_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("resp_data_idle", resp_data, '0);
      end
    end
  end

  task automatic idle_in();
    alloc_valid = 0; ret_valid = 0;
  endtask

  task automatic do_alloc(input logic [IW-1:0] id);
    idle_in(); alloc_valid = 1; alloc_id = id;
    step();
    alloc_valid = 0;
  endtask

  task automatic fill(input int tag, input logic [DW-1:0] base);
    for (int b = 0; b < BL; b++) begin
      idle_in(); ret_valid = 1; ret_tag = XW'(tag); ret_data = base + DW'(b);
      step();
    end
    ret_valid = 0;
  endtask

  // Complete every waiting slot and drain until the model is empty.
  task automatic drain_all();
    int guard = 0;
    resp_ready = 1;
    while ((m_count(M_FREE) != NE || m_busy) && guard < 1000) begin
      int w;
      idle_in();
      w = m_low(M_WAIT);
      if (w >= 0) begin
        ret_valid = 1; ret_tag = XW'(w); ret_data = {$urandom, $urandom};
      end
      step();
      guard++;
    end
    idle_in();
    if (guard >= 1000) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: got %0d free expected %0d", m_count(M_FREE), NE);
    end
  endtask

  initial begin
    model_reset();
    resp_ready = 1;
    #12 rst_n = 1;
    @(posedge clk); #1;

    // Reset then idle
    for (int i = 0; i < 10; i++) step();

    // Single burst, id 3, data A0..A7
    do_alloc(4'd3);
    fill(0, 64'hA0);
    for (int i = 0; i < BL + 2; i++) step();

    // Fill all slots; ninth request ignored; drain slot 5
    for (int i = 0; i < NE; i++) do_alloc(IW'(i + 8));
    do_alloc(4'hF);
    fill(5, 64'h500);
    for (int i = 0; i < BL + 2; i++) step();

    // Slot 4 in SEND (stalled) while 2 then 1 complete; 1 must drain first
    fill(4, 64'h400);
    resp_ready = 0;
    step();
    fill(2, 64'h200);
    fill(1, 64'h100);
    resp_ready = 1;
    for (int i = 0; i < 3 * BL + 6; i++) step();

    // Interleave tags 0 and 1 with a 5-cycle stall mid-drain
    do_alloc(4'd7);
    for (int b = 0; b < BL; b++) begin
      for (int t = 0; t < 2; t++) begin
        idle_in(); ret_valid = 1; ret_tag = XW'(t); ret_data = {$urandom, $urandom};
        step();
      end
    end
    idle_in();
    for (int i = 0; i < 3; i++) step();
    resp_ready = 0;
    for (int i = 0; i < 5; i++) step();
    resp_ready = 1;
    drain_all();

    // Stray beat to a FREE slot: one-cycle pulse
    ret_valid = 1; ret_tag = 3'd6; ret_data = 64'hDEAD;
    step();
    idle_in();
    step();
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      idle_in();
      alloc_valid = ($urandom_range(2) == 0);
      alloc_id    = IW'($urandom);
      if ($urandom_range(9) < 7) begin
        int w = m_low(M_WAIT);
        if ($urandom_range(7) == 0) begin
          ret_valid = 1; ret_tag = XW'($urandom);
        end else if (w >= 0) begin
          int pick = $urandom_range(NE - 1);
          for (int k = 0; k < NE; k++)
            if (m_st[(pick + k) % NE] == M_WAIT) begin w = (pick + k) % NE; break; end
          ret_valid = 1; ret_tag = XW'(w);
        end
        ret_data = {$urandom, $urandom};
      end
      resp_ready = ($urandom_range(3) != 0);
      step();
    end
    drain_all();

    // Reset at beat 3 of a drain
    do_alloc(4'd9);
    fill(0, 64'hC0);
    begin
      int guard = 0;
      resp_ready = 1;
      while (!(m_busy && m_sent == 3) && guard < 50) begin step(); guard++; end
      if (guard >= 50) begin
        n_checks++; n_errors++;
        $display("FAIL reset_setup: got sent %0d expected 3", m_sent);
      end
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_resp_valid", DW'(resp_valid), '0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_free_count", DW'(free_count), DW'(NE));
    chk("rst_alloc_idx", DW'(alloc_idx), '0);
    chk("rst_err_stray", DW'(err_stray), '0);
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step();
    do_alloc(4'd2);
    fill(0, 64'hE0);
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
